// File: rtl/doorbell_responder.sv
// Responder side of the doorbell handshake: launches one engine job per ring,
// waits for completion or timeout, then reports done until busy is cleared.
module doorbell_responder #(
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 busy_in,
    input  logic [TIMEOUT_W-1:0] timeout_cfg,
    input  logic                 engine_done_in,
    input  logic                 err_clr_in,
    output logic                 start_out,
    output logic                 done_out,
    output logic                 active_out,
    output logic                 err_timeout_out,
    output logic [CNT_W-1:0]     job_cnt_out
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TIMEOUT_W-1:0] timer;
    logic                 tmo_en;
    logic                 err_timeout;
    logic [CNT_W-1:0]     job_cnt;
    logic                 tmo_hit;
    logic                 job_finish;

    // Engine completion has priority over a timer expiring in the same cycle.
    assign tmo_hit    = (state == WAIT) && !engine_done_in && tmo_en &&
                        (timer == TIMEOUT_W'(1));
    assign job_finish = (state == WAIT) && (engine_done_in || tmo_hit);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (busy_in) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (job_finish) state_nxt = DONE;
            DONE:    state_nxt = DRAIN;
            // Busy still high means the doorbell lost our done; pulse it again.
            DRAIN:   state_nxt = busy_in ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer       <= '0;
            tmo_en      <= 1'b0;
            err_timeout <= 1'b0;
            job_cnt     <= '0;
        end else begin
            if (state == START) begin
                timer  <= timeout_cfg;
                tmo_en <= (timeout_cfg != '0);
            end else if ((state == WAIT) && !job_finish && tmo_en) begin
                timer <= timer - TIMEOUT_W'(1);
            end

            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr_in) begin
                err_timeout <= 1'b0;
            end

            if (job_finish) begin
                job_cnt <= job_cnt + CNT_W'(1);
            end
        end
    end

    assign start_out       = (state == START);
    assign done_out        = (state == DONE);
    assign active_out      = (state != IDLE);
    assign err_timeout_out = err_timeout;
    assign job_cnt_out     = job_cnt;

endmodule

// File: tb/tb_doorbell_responder.sv
// Testbench for doorbell_responder: a cycle-timed doorbell/engine model feeds
// expected start/done cycles into queues that a negedge monitor consumes.
module tb_doorbell_responder;

    localparam int TW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          busy_in = 1'b0;
    logic [TW-1:0] timeout_cfg = '0;
    logic          engine_done_in = 1'b0;
    logic          err_clr_in = 1'b0;
    logic          start_out;
    logic          done_out;
    logic          active_out;
    logic          err_timeout_out;
    logic [CW-1:0] job_cnt_out;

    int cyc = 0;
    int n_compared = 0;
    int n_mismatched = 0;

    int start_q[$];
    int done_q[$];
    bit exp_active = 1'b0;
    bit exp_err = 1'b0;
    int exp_cnt = 0;
    int model_cnt = 0;
    bit model_err = 1'b0;

    doorbell_responder #(.TIMEOUT_W(TW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .busy_in         (busy_in),
        .timeout_cfg     (timeout_cfg),
        .engine_done_in  (engine_done_in),
        .err_clr_in      (err_clr_in),
        .start_out       (start_out),
        .done_out        (done_out),
        .active_out      (active_out),
        .err_timeout_out (err_timeout_out),
        .job_cnt_out     (job_cnt_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle compare against the model; start/done are expected
    // exactly on the cycles the stimulus side queued up.
    always @(negedge clk) begin
        if (rstn) begin
            bit exp_start;
            bit exp_done;
            exp_start = (start_q.size() != 0) && (start_q[0] == cyc);
            exp_done  = (done_q.size() != 0) && (done_q[0] == cyc);
            check_output("start_out", int'(start_out), int'(exp_start));
            check_output("done_out", int'(done_out), int'(exp_done));
            check_output("active_out", int'(active_out), int'(exp_active));
            check_output("err_timeout_out", int'(err_timeout_out), int'(exp_err));
            check_output("job_cnt_out", int'(job_cnt_out), exp_cnt);
            if (exp_start) void'(start_q.pop_front());
            if (exp_done) void'(done_q.pop_front());
        end
    end

    // Error model for a cycle with no timeout landing on its entry edge.
    task automatic step_model(input bit active);
        if (err_clr_in) model_err = 1'b0;
        exp_err    = model_err;
        exp_active = active;
        exp_cnt    = model_cnt;
    endtask

    task automatic idle_cycles(input int k, input bit noisy);
        for (int i = 0; i < k; i++) begin
            step_model(1'b0);
            busy_in        = 1'b0;
            engine_done_in = noisy && ($urandom_range(0, 4) == 0);
            err_clr_in     = noisy && ($urandom_range(0, 9) == 0);
            tick();
        end
    endtask

    // One doorbell ring. Called at the start of cycle n (busy rises here);
    // lat<=0 means the engine never answers.
    task automatic apply_stimulus(input int tcfg, input int lat, input bit retry,
                                  input int gap, input bit noisy, input bit clr_after);
        int n, s, d, idle_c, stop_c, old_cnt;
        bit to, stray;
        n = cyc;
        s = n + 1;
        to = (tcfg > 0) && ((lat <= 0) || (lat > tcfg));
        d = to ? (s + tcfg + 1) : (s + lat + 1);
        old_cnt   = model_cnt;
        model_cnt = (model_cnt + 1) % 256;
        start_q.push_back(s);
        done_q.push_back(d);
        if (retry) done_q.push_back(d + 2);
        idle_c = retry ? (d + 4) : (d + 2);
        stop_c = idle_c;
        if ((lat > 0) && (s + lat + 1 > stop_c)) stop_c = s + lat + 1;
        for (int c = n; c < stop_c; c++) begin
            if (to && (c == d)) model_err = 1'b1;
            else if (err_clr_in) model_err = 1'b0;
            exp_err    = model_err;
            exp_active = (c >= s) && (c < idle_c);
            exp_cnt    = (c >= d) ? model_cnt : old_cnt;
            busy_in    = (c <= d) || (retry && (c == d + 1));
            timeout_cfg = (c <= s) ? TW'(tcfg) : TW'($urandom_range(0, 65535));
            stray = noisy && ($urandom_range(0, 4) == 0) && ((c <= s) || (c >= d));
            engine_done_in = ((lat > 0) && (c == s + lat)) || stray;
            err_clr_in = (clr_after && (c == d + 1)) || (noisy && ($urandom_range(0, 9) == 0));
            tick();
        end
        idle_cycles(gap, noisy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_start"}, int'(start_out), 0);
        check_output({tag, "_done"}, int'(done_out), 0);
        check_output({tag, "_active"}, int'(active_out), 0);
        check_output({tag, "_err"}, int'(err_timeout_out), 0);
        check_output({tag, "_cnt"}, int'(job_cnt_out), 0);
    endtask

    initial begin
        #1 rstn = 1'b0;
        #1 check_reset_outputs("reset_initial");
        tick();
        tick();
        rstn = 1'b1;
        idle_cycles(2, 1'b0);

        apply_stimulus(0, 4, 1'b0, 2, 1'b0, 1'b0);
        apply_stimulus(5, 0, 1'b0, 2, 1'b0, 1'b1);
        apply_stimulus(3, 3, 1'b0, 1, 1'b0, 1'b0);
        apply_stimulus(0, 2, 1'b1, 1, 1'b0, 1'b0);
        apply_stimulus(7, 2, 1'b0, 0, 1'b0, 1'b0);
        apply_stimulus(2, 9, 1'b0, 0, 1'b0, 1'b0);

        // Ring, reach WAIT, then pull reset: no done may follow.
        start_q.push_back(cyc + 1);
        for (int i = 0; i < 4; i++) begin
            step_model(i != 0);
            busy_in        = 1'b1;
            timeout_cfg    = '0;
            engine_done_in = 1'b0;
            err_clr_in     = 1'b0;
            tick();
        end
        #2 rstn = 1'b0;
        #1 check_reset_outputs("reset_mid_wait");
        model_cnt = 0;
        model_err = 1'b0;
        busy_in = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        exp_active = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;

        for (int j = 0; j < 300; j++) begin
            int tcfg;
            tcfg = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
            apply_stimulus(tcfg, int'($urandom_range(1, 20)), ($urandom_range(0, 9) == 0),
                           int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end
        idle_cycles(5, 1'b0);
        check_output("final_job_cnt", int'(job_cnt_out), model_cnt);
        check_output("final_model_cnt_is_44", model_cnt, int'(job_cnt_out) == 44 ? model_cnt : 44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/doorbell_responder.md
# doorbell_responder

Responder side of the doorbell handshake. It watches the doorbell's `busy` level and launches one job per ring on a downstream engine with a single-cycle `start` pulse. It waits for the engine to finish, with an optional timeout, then pulses `done` back to the doorbell and holds off until the doorbell has actually cleared `busy`. It sits between the doorbell block (its `busy_out` drives `busy_in`; its `done_out` drives the doorbell's `done_in`) and a worker engine.

## Interface
- `TIMEOUT_W`, 16, width of the timeout configuration and timer
- `CNT_W`, 8, width of the completed-job counter
- `clk`  in  1  clock; all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `busy_in`  in  1  doorbell busy level
- `timeout_cfg`  in  TIMEOUT_W  max WAIT cycles; 0 disables the timeout
- `engine_done_in`  in  1  engine completion pulse/level
- `err_clr_in`  in  1  clears sticky timeout error
- `start_out`  out  1  one-cycle job launch to engine
- `done_out`  out  1  one-cycle completion to doorbell `done_in`
- `active_out`  out  1  high whenever state != IDLE
- `err_timeout_out`  out  1  sticky; set on timeout completion
- `job_cnt_out`  out  CNT_W  completed jobs (normal + timed-out), wraps

## Operation
- State machine states: IDLE, START, WAIT, DONE, DRAIN. The state register is one-hot or binary; this is an implementation choice.
- Outputs are Moore decodes of registered state, or are themselves registered:
  - `start_out` = (state==START)
  - `done_out` = (state==DONE)
  - `active_out` = (state!=IDLE)
- IDLE: if `busy_in`=1, go to START.
- START: go to WAIT unconditionally. On this edge, load timer <= `timeout_cfg` and latch a local copy of tmo_en = (`timeout_cfg`!=0).
- WAIT:
  - If `engine_done_in`=1, go to DONE (normal).
  - Otherwise, if tmo_en and timer==1, go to DONE with timeout: set `err_timeout_out`.
  - Otherwise decrement the timer when tmo_en.
  - If done and timer expiry occur in the same cycle, done wins: no error.
  - `engine_done_in` is ignored in every state except WAIT.
- DONE: go to DRAIN. On entry from WAIT, `job_cnt_out` increments by 1 (mod 2^CNT_W). Re-entry from DRAIN does not increment.
- DRAIN:
  - If `busy_in`=0, go to IDLE.
  - If `busy_in`=1, go back to DONE to re-pulse `done_out`. This is needed because the doorbell drops `done_in` when it coincides with a new set.
  - Retries are unbounded.
- Error clear:
  - `err_clr_in` clears `err_timeout_out`.
  - A timeout set in the same cycle as a clear wins; the error stays 1.
- `timeout_cfg` is sampled only in START. Changes during WAIT have no effect on the current job.
- The block handles exactly one job in flight. A new ring is only recognised after returning to IDLE.

## Timing
- Reset values: state=IDLE, `start_out`=0, `done_out`=0, `active_out`=0, `err_timeout_out`=0, `job_cnt_out`=0, timer=0.
- Reset is asynchronous. Asserting it mid-operation forces IDLE and all the values above immediately. No `done_out` is emitted for the aborted job.
- Ring latency: `busy_in` high in cycle n (state IDLE) gives `start_out` high in cycle n+1 only.
- First WAIT cycle is n+2. `engine_done_in` high in WAIT cycle k gives `done_out` high in cycle k+1.
- Minimum ring-to-done: 3 cycles (engine done in the first WAIT cycle).
- Timeout: with `timeout_cfg`=T>0 and no engine done, WAIT lasts exactly T cycles. `done_out` and `err_timeout_out` rise together in cycle n+2+T.
- `job_cnt_out` updates on the same edge on which `done_out` rises.
- Normal return: `done_out` high in cycle d, doorbell clears busy so `busy_in`=0 in d+1 (DRAIN), IDLE in d+2.
- Earliest next `start_out`: d+3 if `busy_in` is high in d+2.
- Retry: `busy_in` still 1 in d+1 gives a second `done_out` in d+2.

## Test plan
- Basic job: `timeout_cfg`=0, raise `busy_in`, engine done 4 cycles after `start_out` -> one `start_out`, one `done_out` 5 cycles after start, `job_cnt_out`=1, `err_timeout_out`=0, back to IDLE after `busy_in` falls.
- Timeout: `timeout_cfg`=5, engine silent -> `done_out` and `err_timeout_out`=1 exactly 6 cycles after `start_out`, `job_cnt_out`=1. Then `err_clr_in` -> error 0 next cycle.
- Done vs timeout tie: `timeout_cfg`=3, engine done in the 3rd WAIT cycle -> normal completion, `err_timeout_out` stays 0.
- Lost done retry: doorbell model holds `busy_in`=1 after the first `done_out` -> second `done_out` 2 cycles later, `job_cnt_out` increments only once. `busy_in` then drops -> IDLE.
- Back-to-back rings: 300 jobs with random engine latency 1–20 -> exactly one `start_out` per `done_out`, `job_cnt_out`=300 mod 256=44. Stray `engine_done_in` in IDLE/START/DRAIN is ignored.
- Reset mid-WAIT: assert `rstn`=0 during WAIT -> all outputs 0 asynchronously, no `done_out`. After release with `busy_in`=1, a fresh `start_out` follows.
